// File: rtl/rx_fifo_arb_if.sv
// Bundle of the receive-side, downstream-FIFO and status signals for rx_fifo_arb.
// The "master" side is the surrounding system; the arbiter itself uses "slave".
interface rx_fifo_arb_if;
    logic [31:0] in0_data;
    logic        in0_en;
    logic [31:0] in1_data;
    logic        in1_en;
    logic        fifo_full;
    logic        cnt_clr;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic [15:0] drop0_cnt;
    logic [15:0] drop1_cnt;

    modport master (
        output in0_data, in0_en, in1_data, in1_en, fifo_full, cnt_clr,
        input  fifo_din, fifo_wr_en, drop0_cnt, drop1_cnt
    );

    modport slave (
        input  in0_data, in0_en, in1_data, in1_en, fifo_full, cnt_clr,
        output fifo_din, fifo_wr_en, drop0_cnt, drop1_cnt
    );
endinterface

// File: rtl/rx_fifo_arb.sv
// Two-source receive arbiter: each receiver feeds a small private queue, and a
// word-level round-robin arbiter drains both queues into one downstream FIFO,
// tagging every word with its source id in bit 31. Words that arrive at a full
// queue are discarded and counted in saturating per-source drop counters.
module rx_fifo_arb #(
    parameter int DEPTH = 4  // per-source queue depth, power of 2, >= 2
) (
    input  logic          clk125,
    input  logic          sys_rst,
    rx_fifo_arb_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;  // extra MSB tells full from empty
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [1:0]  in_en;
    logic [28:0] in_pay [2];
    logic [28:0] mem    [2][DEPTH];
    logic [28:0] head   [2];
    ptr_t        wr_ptr [2];
    ptr_t        rd_ptr [2];
    logic [1:0]  empty;
    logic [1:0]  full;
    logic [1:0]  pop;
    logic [1:0]  push;
    logic [1:0]  drop;
    logic        grant;
    logic        last_grant;
    logic [15:0] drop_cnt [2];
    logic        unused_hi_bits;

    assign in_en     = {bus.in1_en, bus.in0_en};
    assign in_pay[0] = bus.in0_data[28:0];
    assign in_pay[1] = bus.in1_data[28:0];
    assign head[0]   = mem[0][rd_ptr[0][AW-1:0]];
    assign head[1]   = mem[1][rd_ptr[1][AW-1:0]];

    // Bits 31:29 of the receiver words carry no payload and are replaced by the tag.
    assign unused_hi_bits = ^{bus.in0_data[31:29], bus.in1_data[31:29]};

    // Queue status decoded from the pointer MSB and the index bits.
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
        empty = '0;
        full  = '0;
        for (int i = 0; i < 2; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    // Round-robin grant: on a tie the source that did not win last time goes next.
    always_comb begin
        pop   = '0;
        grant = 1'b0;
        if (!bus.fifo_full && (empty != 2'b11)) begin
            if (empty == 2'b00) begin
                grant = ~last_grant;
            end else begin
                grant = empty[0];  // only source 1 has data when queue 0 is empty
            end
            pop = grant ? 2'b10 : 2'b01;
        end
    end

    // A full queue still takes a word when it is popped on the same edge.
    always_comb begin
        push = '0;
        drop = '0;
        for (int i = 0; i < 2; i++) begin
            push[i] = in_en[i] && (!full[i] || pop[i]);
            drop[i] = in_en[i] &&  full[i] && !pop[i];
        end
    end

    // Queue pointers; reset empties both queues at once.
    always_ff @(posedge clk125 or posedge sys_rst) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (sys_rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            end
        end
    end

    // Queue storage writes.
    always_ff @(posedge clk125) begin
        // NOTE: storage has no reset; emptiness is defined by the pointers alone.
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= in_pay[i];
        end
    end

    // Registered output word, write strobe and arbitration history.
    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            bus.fifo_wr_en <= 1'b0;
            bus.fifo_din   <= 32'h0;
            last_grant     <= 1'b1;
        end else begin
            bus.fifo_wr_en <= |pop;
            if (|pop) begin
                bus.fifo_din <= {grant, 2'b00, (grant ? head[1] : head[0])};
                last_grant   <= grant;
            end
        end
    end

    // Saturating drop counters; a clear coincident with a drop leaves a count of one.
    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            drop_cnt[0] <= '0;
            drop_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (bus.cnt_clr) begin
                    drop_cnt[i] <= drop[i] ? 16'd1 : 16'd0;
                end else if (drop[i] && (drop_cnt[i] != 16'hFFFF)) begin
                    drop_cnt[i] <= drop_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign bus.drop0_cnt = drop_cnt[0];
    assign bus.drop1_cnt = drop_cnt[1];

endmodule

// File: doc/rx_fifo_arb.md
RX_FIFO_ARB -- requirements
Module: rx_fifo_arb

Interface
REQ-001 Parameter: DEPTH, 4, per-source queue depth in 32-bit words; must be a power of 2 and at least 2.
REQ-002 Port: clk125  input  1  single clock for all logic.
REQ-003 Port: sys_rst  input  1  asynchronous active-high reset.
REQ-004 Port: in0_data  input  32  word from receiver 0; bits 28:0 carry payload.
REQ-005 Port: in0_en  input  1  in0_data valid this cycle; cannot be back-pressured.
REQ-006 Port: in1_data  input  32  word from receiver 1; bits 28:0 carry payload.
REQ-007 Port: in1_en  input  1  in1_data valid this cycle; cannot be back-pressured.
REQ-008 Port: fifo_full  input  1  downstream FIFO cannot accept a write this cycle.
REQ-009 Port: cnt_clr  input  1  synchronous clear pulse for the drop counters.
REQ-010 Port: fifo_din  output  32  tagged word to the FIFO, registered.
REQ-011 Port: fifo_wr_en  output  1  one-cycle write strobe qualifying fifo_din, registered.
REQ-012 Port: drop0_cnt  output  16  saturating count of words lost from source 0.
REQ-013 Port: drop1_cnt  output  16  saturating count of words lost from source 1.

Function
REQ-014 Each source SHALL have its own DEPTH-entry FIFO queue. inN_en SHALL push inN_data on the rising clock edge.
REQ-015 A push to a full queue SHALL be accepted if that queue is popped on the same edge. Otherwise the word SHALL be discarded and dropN_cnt SHALL increment by 1.
REQ-016 dropN_cnt SHALL saturate at 16'hFFFF.
REQ-017 cnt_clr SHALL set both drop counters to 0. If a drop occurs on the same edge, that counter SHALL be set to 1.
REQ-018 On each edge where fifo_full=0 and at least one queue is non-empty, exactly one queue SHALL be popped.
REQ-019 When fifo_full=1, no queue SHALL be popped and fifo_wr_en SHALL be 0 in the next cycle.
REQ-020 Arbitration SHALL be word-level round-robin using a last_grant register, reset value 1 so that source 0 wins the first tie.
REQ-021 When both queues are non-empty, the source not equal to last_grant SHALL be granted. When only one queue is non-empty, that source SHALL be granted. last_grant SHALL update on every pop.
REQ-022 The popped word SHALL be presented as fifo_din = {src_id, 2'b00, data[28:0]} with fifo_wr_en=1 for one cycle; src_id is 0 for source 0 and 1 for source 1.
REQ-023 If no pop occurs, fifo_wr_en SHALL be 0 and fifo_din SHALL hold its previous value.
REQ-024 Latency: a word pushed on edge k into an empty queue, with no competing traffic and fifo_full=0, SHALL appear with fifo_wr_en=1 after edge k+1.
REQ-025 Word order within each source SHALL be preserved. No word SHALL be duplicated.
REQ-026 Queue read/write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full/empty SHALL be decoded from the pointer MSB and the remaining bits.
REQ-027 Sustained load of one word per 2 cycles per source, with fifo_full=0, SHALL produce zero drops.

Reset
REQ-028 Asserting sys_rst, including mid-packet, SHALL immediately empty both queues.
REQ-029 sys_rst SHALL also clear fifo_wr_en=0, fifo_din=32'h0, drop0_cnt=0, drop1_cnt=0 and set last_grant=1.
REQ-030 Words arriving while sys_rst is high SHALL be ignored and SHALL NOT be counted as drops.
REQ-031 After sys_rst deasserts, the first in0_en or in1_en SHALL be accepted normally.

Verification
REQ-032 Single word: in0_data=32'h0ABC_DEF0, in0_en pulsed once, fifo_full=0 -> fifo_din=32'h0ABC_DEF0 with fifo_wr_en=1 two edges later, asserted exactly once.
REQ-033 Tie: in0 and in1 each push one word on the same edge -> source 0 written first, then source 1, with fifo_din[31]=0 then 1; zero drops.
REQ-034 Back-pressure: fifo_full=1 while source 0 pushes 6 words with DEPTH=4 -> 4 queued, drop0_cnt=2. After fifo_full falls -> the first 4 words are written in order.
REQ-035 Full queue: with queue 0 full, a push and a pop on the same edge -> push accepted, drop0_cnt unchanged.
REQ-036 Saturation/clear: drop1_cnt preloaded to 16'hFFFF by forcing drops, then one more drop -> stays 16'hFFFF. cnt_clr coincident with a drop -> drop1_cnt=1.
REQ-037 Reset mid-stream: sys_rst asserted while both queues hold 3 words -> fifo_wr_en=0 immediately, queues empty, counters 0. After release, no stale words are written.
